// File: rtl/al_phy_dpram16x4.sv
// 16x4 distributed RAM behind the logic slice's write interface: one-stage write
// pipeline, optional write-first read bypass and a reset-triggered INIT reload.
module al_phy_dpram16x4 #(
    parameter logic [63:0] INIT        = 64'h0,
    parameter string       WRITE_FIRST = "OFF",
    parameter string       RST_INIT    = "ON"
) (
    input  logic       clk,
    input  logic       sr,
    input  logic       dpram_mode,
    input  logic       dpram_we,
    input  logic [3:0] dpram_waddr,
    input  logic [3:0] dpram_di,
    input  logic [3:0] raddr0,
    input  logic [3:0] raddr1,
    output logic [3:0] do0,
    output logic [3:0] do1,
    output logic       busy,
    output logic       wr_ack,
    output logic [0:0] dbg_state
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    localparam logic WF_ON     = (WRITE_FIRST == "ON");
    localparam logic RELOAD_ON = (RST_INIT == "ON");

    // Power-up contents and state come from declaration initialisers (FPGA init).
    logic [63:0] mem_q     = INIT;
    logic [63:0] mem_d;
    logic [0:0]  state_q   = ST_RUN;
    logic [0:0]  state_d;
    logic [3:0]  cnt_q     = 4'h0;
    logic [3:0]  cnt_d;
    logic        pend_v_q  = 1'b0;
    logic        pend_v_d;
    logic [3:0]  pend_a_q  = 4'h0;
    logic [3:0]  pend_a_d;
    logic [3:0]  pend_d_q  = 4'h0;
    logic [3:0]  pend_d_d;
    logic        wr_ack_q  = 1'b0;
    logic        wr_ack_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_v_d = pend_v_q;
        pend_a_d = pend_a_q;
        pend_d_d = pend_d_q;
        wr_ack_d = wr_ack_q;
        mem_d    = mem_q;
        if (sr) begin
            state_d = RELOAD_ON ? ST_LOAD : ST_RUN;
        end else if (state_q == ST_LOAD) begin
            // Requests arriving during reload are dropped, not queued.
            mem_d[{cnt_q, 2'b00} +: 4] = INIT[{cnt_q, 2'b00} +: 4];
            cnt_d    = cnt_q + 4'h1;
            pend_v_d = 1'b0;
            wr_ack_d = 1'b0;
            if (cnt_q == 4'hF) begin
                state_d = ST_RUN;
            end
        end else begin
            pend_v_d = dpram_mode & dpram_we;
            if (dpram_mode & dpram_we) begin
                pend_a_d = dpram_waddr;
                pend_d_d = dpram_di;
            end
            // Ternary per entry so an unknown commit or address poisons the entries.
            for (int i = 0; i < 16; i++) begin
                mem_d[4*i +: 4] = (pend_v_q && (pend_a_q == 4'(i))) ? pend_d_q : mem_q[4*i +: 4];
            end
            wr_ack_d = pend_v_q;
        end
    end

    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        state_q <= state_d;
        if (sr) begin
            cnt_q    <= 4'h0;
            pend_v_q <= 1'b0;
            pend_a_q <= 4'h0;
            pend_d_q <= 4'h0;
            wr_ack_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pend_v_q <= pend_v_d;
            pend_a_q <= pend_a_d;
            pend_d_q <= pend_d_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    always_comb begin
        do0 = mem_q[{raddr0, 2'b00} +: 4];
        do1 = mem_q[{raddr1, 2'b00} +: 4];
        if (WF_ON && pend_v_q && (raddr0 == pend_a_q)) begin
            do0 = pend_d_q;
        end
        if (WF_ON && pend_v_q && (raddr1 == pend_a_q)) begin
            do1 = pend_d_q;
        end
    end

    assign busy      = (state_q == ST_LOAD);
    assign wr_ack    = wr_ack_q;
    assign dbg_state = state_q;

endmodule
